// File: rtl/read_data_split_merge_pkg.sv
// Shared read-split definitions: half-width and pad-width helpers plus the
// even-width check. The split-mode write address translator uses the same
// helpers, so both sides agree on how a wide address/word is halved.
// No ports (package).
package read_data_split_merge_pkg;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

    // Zero bits placed above the selected address half in the local address.
    function automatic int pad_width(input int local_w, input int wide_w);
        return local_w - (wide_w / 2);
    endfunction

    function automatic bit is_even(input int w);
        return (w % 2) == 0;
    endfunction

endpackage

// File: rtl/read_data_split_merge_delay_line.sv
// read_split_delay_line: WIDTH x DEPTH shift register with synchronous
// active-low clear. Advances every cycle; all stages are exposed so the
// parent can OR the valid bits into a busy flag.
// Ports:
//   clock    in   rising-edge clock
//   clear_n  in   synchronous active-low clear of every stage
//   data_in  in   [WIDTH-1:0] value entering stage 0
//   stages   out  [DEPTH-1:0][WIDTH-1:0] all stages, stages[DEPTH-1] is the oldest
module read_split_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic [WIDTH-1:0]            data_in,
    output logic [DEPTH-1:0][WIDTH-1:0] stages
);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            stages <= '0;
        end else begin
            stages[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

endmodule

// File: rtl/read_data_split_merge.sv
// read_data_split_merge: read-side companion of the split-mode write address
// translator. Issues a registered local RAM address (plain: truncated wide
// address; split: selected address half, zero-padded), tracks each request's
// split bit through the fixed RAM latency and realigns the returned word.
// In split mode the lower and upper instances are OR-merged downstream.
// Optional feature: define READ_SPLIT_PERF_COUNT_EN to add split_read_count.
// Ports:
//   clock             in   rising-edge clock
//   reset_n           in   synchronous active-low reset
//   split             in   split mode, sampled per request
//   read_valid        in   read request this cycle
//   read_addr         in   [READ_ADDR_WIDTH-1:0] wide read address
//   ram_read_addr     out  [READ_ADDR_WIDTH_LOCAL-1:0] registered local address
//   ram_read_data     in   [WORD_WIDTH-1:0] RAM data, RAM_READ_LATENCY after address
//   read_data         out  [WORD_WIDTH-1:0] realigned data, held when not valid
//   read_data_valid   out  read_data holds a completed request
//   busy              out  any request in flight
//   split_read_count  out  [31:0] completed split reads (READ_SPLIT_PERF_COUNT_EN only)
module read_data_split_merge
    import read_data_split_merge_pkg::*;
#(
    parameter int READ_ADDR_WIDTH       = 10,
    parameter int READ_ADDR_WIDTH_LOCAL = 10,
    parameter int WORD_WIDTH            = 36,
    parameter int LOWER_UPPER_SPLIT     = 0,
    parameter int RAM_READ_LATENCY      = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             split,
    input  logic                             read_valid,
    input  logic [READ_ADDR_WIDTH-1:0]       read_addr,
    output logic [READ_ADDR_WIDTH_LOCAL-1:0] ram_read_addr,
    input  logic [WORD_WIDTH-1:0]            ram_read_data,
    output logic [WORD_WIDTH-1:0]            read_data,
    output logic                             read_data_valid,
    output logic                             busy
`ifdef READ_SPLIT_PERF_COUNT_EN
    ,
    output logic [31:0]                      split_read_count
`endif
);

    localparam int ADDR_HALF = half_width(READ_ADDR_WIDTH);
    localparam int DATA_HALF = half_width(WORD_WIDTH);
    localparam int DEPTH     = RAM_READ_LATENCY + 1;

    generate
        if (!is_even(READ_ADDR_WIDTH)) begin : g_bad_addr_width
            $error("READ_ADDR_WIDTH must be even");
        end
        if (!is_even(WORD_WIDTH)) begin : g_bad_word_width
            $error("WORD_WIDTH must be even");
        end
        if (pad_width(READ_ADDR_WIDTH_LOCAL, READ_ADDR_WIDTH) < 0) begin : g_bad_local_width
            $error("READ_ADDR_WIDTH_LOCAL must be >= READ_ADDR_WIDTH/2");
        end
        if (RAM_READ_LATENCY < 1) begin : g_bad_latency
            $error("RAM_READ_LATENCY must be >= 1");
        end
    endgenerate

    // Issue stage: address translation (truncation / zero padding, no carry).
    logic [ADDR_HALF-1:0]             addr_half;
    logic [READ_ADDR_WIDTH_LOCAL-1:0] issue_addr;

    always_comb begin
        addr_half  = '0;
        issue_addr = '0;
        if (LOWER_UPPER_SPLIT != 0) begin
            addr_half = read_addr[READ_ADDR_WIDTH-1 -: ADDR_HALF];
        end else begin
            addr_half = read_addr[ADDR_HALF-1:0];
        end
        if (split) begin
            issue_addr = READ_ADDR_WIDTH_LOCAL'(addr_half);
        end else begin
            issue_addr = READ_ADDR_WIDTH_LOCAL'(read_addr);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ram_read_addr <= '0;
        end else if (read_valid) begin
            ram_read_addr <= issue_addr;
        end
    end

    // Tracking: {valid, split}; split is gated so idle slots carry all zeros.
    logic [DEPTH-1:0][1:0] track;
    logic                  emerge_valid;
    logic                  emerge_split;

    read_split_delay_line #(
        .WIDTH (2),
        .DEPTH (DEPTH)
    ) u_track (
        .clock   (clock),
        .clear_n (reset_n),
        .data_in ({read_valid, read_valid & split}),
        .stages  (track)
    );

    assign emerge_valid = track[DEPTH-1][1];
    assign emerge_split = track[DEPTH-1][0];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | track[i][1];
        end
    end

    // Realign stage: in split mode the RAM's low half lands in this
    // instance's half of the wide word, the other half stays zero.
    logic [DATA_HALF-1:0]  ram_low;
    logic [WORD_WIDTH-1:0] aligned;

    assign ram_low = ram_read_data[DATA_HALF-1:0];

    always_comb begin
        aligned = ram_read_data;
        if (emerge_split) begin
            if (LOWER_UPPER_SPLIT != 0) begin
                aligned = {ram_low, {DATA_HALF{1'b0}}};
            end else begin
                aligned = {{DATA_HALF{1'b0}}, ram_low};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data_valid <= emerge_valid;
            if (emerge_valid) begin
                read_data <= aligned;
            end
        end
    end

`ifdef READ_SPLIT_PERF_COUNT_EN
    // Counts every completed split request; updates on the same edge that
    // raises read_data_valid for it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            split_read_count <= '0;
        end else if (emerge_valid && emerge_split) begin
            split_read_count <= split_read_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_data_split_merge.sv
module tb_read_data_split_merge;

    localparam int AW  = 10;
    localparam int LW  = 10;
    localparam int WW  = 36;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          split = 1'b0;
    logic          read_valid = 1'b0;
    logic [AW-1:0] read_addr = '0;

    logic [LW-1:0] ra_lo, ra_hi;
    logic [WW-1:0] rd_lo, rd_hi, rdo_lo, rdo_hi;
    logic          v_lo, v_hi, b_lo, b_hi;
`ifdef READ_SPLIT_PERF_COUNT_EN
    logic [31:0]   cnt_lo, cnt_hi;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    read_data_split_merge #(
        .READ_ADDR_WIDTH(AW), .READ_ADDR_WIDTH_LOCAL(LW), .WORD_WIDTH(WW),
        .LOWER_UPPER_SPLIT(0), .RAM_READ_LATENCY(LAT)
    ) dut_lo (
        .clock(clock), .reset_n(reset_n), .split(split), .read_valid(read_valid),
        .read_addr(read_addr), .ram_read_addr(ra_lo), .ram_read_data(rd_lo),
        .read_data(rdo_lo), .read_data_valid(v_lo), .busy(b_lo)
`ifdef READ_SPLIT_PERF_COUNT_EN
        , .split_read_count(cnt_lo)
`endif
    );

    read_data_split_merge #(
        .READ_ADDR_WIDTH(AW), .READ_ADDR_WIDTH_LOCAL(LW), .WORD_WIDTH(WW),
        .LOWER_UPPER_SPLIT(1), .RAM_READ_LATENCY(LAT)
    ) dut_hi (
        .clock(clock), .reset_n(reset_n), .split(split), .read_valid(read_valid),
        .read_addr(read_addr), .ram_read_addr(ra_hi), .ram_read_data(rd_hi),
        .read_data(rdo_hi), .read_data_valid(v_hi), .busy(b_hi)
`ifdef READ_SPLIT_PERF_COUNT_EN
        , .split_read_count(cnt_hi)
`endif
    );

    // RAM models: fixed-latency reads from a shared content array.
    logic [WW-1:0] mem [1024];
    logic [WW-1:0] pipe_lo [LAT];
    logic [WW-1:0] pipe_hi [LAT];

    always @(posedge clock) begin
        pipe_lo[0] <= mem[ra_lo];
        pipe_hi[0] <= mem[ra_hi];
        for (int i = 1; i < LAT; i++) begin
            pipe_lo[i] <= pipe_lo[i-1];
            pipe_hi[i] <= pipe_hi[i-1];
        end
    end
    assign rd_lo = pipe_lo[LAT-1];
    assign rd_hi = pipe_hi[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference model: per-request arithmetic on addresses and words.
    function automatic logic [LW-1:0] xlate(input logic [AW-1:0] a, input logic sp, input bit upper);
        int v;
        v = int'(a);
        if (sp) v = upper ? (v / 32) : (v % 32);
        else    v = v % 1024;
        return LW'(v);
    endfunction

    function automatic logic [WW-1:0] realign(input logic [WW-1:0] d, input logic sp, input bit upper);
        logic [WW-1:0] low;
        low = d & 36'h3FFFF;
        if (!sp) return d;
        return upper ? (low << 18) : low;
    endfunction

    typedef struct {
        int            due;
        int            issue;
        logic [AW-1:0] addr;
        logic          sp;
    } req_t;

    req_t          q[$];
    bit            rst_seen = 0;
    logic [WW-1:0] exp_d_lo = '0, exp_d_hi = '0;
    logic [LW-1:0] exp_a_lo = '0, exp_a_hi = '0;
    int            exp_cnt = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (rst_seen) begin
                logic exp_v;
                logic exp_busy;
                req_t r;
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                if (exp_v) begin
                    r = q.pop_front();
                    exp_d_lo = realign(mem[xlate(r.addr, r.sp, 0)], r.sp, 0);
                    exp_d_hi = realign(mem[xlate(r.addr, r.sp, 1)], r.sp, 1);
                    if (r.sp) exp_cnt++;
                end
                chk("valid_lo", 64'(v_lo), 64'(exp_v));
                chk("valid_hi", 64'(v_hi), 64'(exp_v));
                chk("data_lo", 64'(rdo_lo), 64'(exp_d_lo));
                chk("data_hi", 64'(rdo_hi), 64'(exp_d_hi));
                chk("addr_lo", 64'(ra_lo), 64'(exp_a_lo));
                chk("addr_hi", 64'(ra_hi), 64'(exp_a_hi));
                exp_busy = 1'b0;
                foreach (q[i]) if (q[i].issue < cyc) exp_busy = 1'b1;
                chk("busy_lo", 64'(b_lo), 64'(exp_busy));
                chk("busy_hi", 64'(b_hi), 64'(exp_busy));
`ifdef READ_SPLIT_PERF_COUNT_EN
                chk("count_lo", 64'(cnt_lo), 64'(exp_cnt));
                chk("count_hi", 64'(cnt_hi), 64'(exp_cnt));
`endif
            end
            if (!reset_n) begin
                q.delete();
                exp_d_lo = '0; exp_d_hi = '0;
                exp_a_lo = '0; exp_a_hi = '0;
                exp_cnt  = 0;
                rst_seen = 1;
            end else if (read_valid) begin
                q.push_back('{due: cyc + LAT + 2, issue: cyc, addr: read_addr, sp: split});
                exp_a_lo = xlate(read_addr, split, 0);
                exp_a_hi = xlate(read_addr, split, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic sp);
        read_valid = 1'b1;
        read_addr  = a;
        split      = sp;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {4'($urandom), 32'($urandom)};
        mem[10'h007] = 36'hF_0001_2345;
        mem[10'h01F] = 36'hC_0001_2345;

        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        chk("reset_valid", 64'(v_lo), 64'd0);
        chk("reset_data", 64'(rdo_hi), 64'd0);
        chk("reset_busy", 64'(b_lo), 64'd0);
        tick();

        // Plain read, latency pin.
        drive(10'h2A5, 1'b0);
        read_valid = 1'b0;
        @(negedge clock);
        chk("plain_addr", 64'(ra_lo), 64'h2A5);
        repeat (2) tick();
        @(negedge clock);
        chk("plain_early", 64'(v_lo), 64'd0);
        tick();
        @(negedge clock);
        chk("plain_valid", 64'(v_lo), 64'd1);
        chk("plain_data", 64'(rdo_lo), 64'(mem[10'h2A5]));
        repeat (2) tick();

        // Split lower / upper.
        drive(10'h3E7, 1'b1);
        read_valid = 1'b0;
        @(negedge clock);
        chk("split_addr_lo", 64'(ra_lo), 64'h007);
        chk("split_addr_hi", 64'(ra_hi), 64'h01F);
        repeat (3) tick();
        @(negedge clock);
        chk("split_valid", 64'(v_hi), 64'd1);
        chk("split_data_lo", 64'(rdo_lo), 64'h0_0001_2345);
        chk("split_data_hi", 64'(rdo_hi), 64'h4_8D14_0000);
        repeat (2) tick();

        // Split toggles between consecutive requests.
        drive(10'h155, 1'b1);
        drive(10'h2AA, 1'b0);
        read_valid = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        chk("toggle_a_valid", 64'(v_lo), 64'd1);
        tick();
        @(negedge clock);
        chk("toggle_b_valid", 64'(v_lo), 64'd1);
        chk("toggle_b_data", 64'(rdo_hi), 64'(mem[10'h2AA]));
        repeat (2) tick();

        // Reset mid-flight.
        drive(10'h011, 1'b0);
        drive(10'h122, 1'b1);
        drive(10'h233, 1'b0);
        read_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("flush_valid", 64'(v_lo | v_hi), 64'd0);
            chk("flush_busy", 64'(b_lo | b_hi), 64'd0);
            chk("flush_data", 64'(rdo_lo | rdo_hi), 64'd0);
            chk("flush_addr", 64'(ra_lo | ra_hi), 64'd0);
            tick();
        end

`ifdef READ_SPLIT_PERF_COUNT_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(AW'($urandom), (i < 5) ? 1'b1 : 1'b0);
        read_valid = 1'b0;
        repeat (6) tick();
        @(negedge clock);
        chk("perf_count", 64'(cnt_lo), 64'd5);
        tick();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            read_valid = ($urandom_range(0, 3) != 0);
            split      = 1'($urandom);
            read_addr  = AW'($urandom);
            reset_n    = ($urandom_range(0, 149) != 0);
            tick();
        end
        read_valid = 1'b0;
        reset_n    = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
